// File: rtl/fifo_wr_burst.sv
// rtl/fifo_wr_burst.sv - write-side burst controller feeding the async FIFO write port
// Optional macro FIFO_WR_THROTTLE_ALMOST_EN: halve the write rate while wfull_almost is set.
module fifo_wr_burst #(
  parameter int DSIZE     = 8,
  parameter int LENW      = 8,
  parameter int STALL_MAX = 16,
  parameter int CNTW      = 16
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic             burst_start,
  input  logic [LENW-1:0]  burst_len,
  input  logic             in_valid,
  input  logic [DSIZE-1:0] in_data,
  output logic             in_ready,
  output logic             winc,
  output logic [DSIZE-1:0] wdata,
  input  logic             wfull,
  input  logic             wfull_almost,
  input  logic             fifo_error_w,
  input  logic             err_clr,
  output logic             burst_busy,
  output logic             burst_done,
  output logic [CNTW-1:0]  words_written,
  output logic             err_timeout,
  output logic             err_overflow
);

  localparam int SW = (STALL_MAX > 1) ? $clog2(STALL_MAX) : 1;

  typedef enum logic [1:0] {IDLE, BURST, STALL, DONE} state_t;

  state_t          state;
  logic [LENW-1:0] rem;
  logic [SW-1:0]   stall_cnt;
  logic            throttle;
  logic            timeout;

`ifdef FIFO_WR_THROTTLE_ALMOST_EN
  logic last_acc;

  // Block the cycle right after an accept while the FIFO is nearly full.
  assign throttle = wfull_almost & last_acc;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) last_acc <= 1'b0;
    else         last_acc <= (state == BURST) & winc;
  end
`else
  logic unused_almost;
  assign unused_almost = wfull_almost;
  assign throttle      = 1'b0;
`endif

  assign in_ready = (state == BURST) & ~wfull & ~throttle;
  assign winc     = in_valid & in_ready;
  assign wdata    = in_data;
  assign timeout  = (state == STALL) & wfull & (stall_cnt == SW'(STALL_MAX - 1));

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state      <= IDLE;
      rem        <= '0;
      stall_cnt  <= '0;
      burst_busy <= 1'b0;
      burst_done <= 1'b0;
    end else begin
      burst_done <= 1'b0;
      case (state)
        IDLE: begin
          if (burst_start && burst_len != '0) begin
            state      <= BURST;
            rem        <= burst_len;
            burst_busy <= 1'b1;
          end
        end
        BURST: begin
          if (winc) begin
            if (rem != '0) rem <= rem - 1'b1;
            if (rem == LENW'(1)) begin
              state      <= DONE;
              burst_done <= 1'b1;
              burst_busy <= 1'b0;
            end
          end else if (wfull) begin
            state     <= STALL;
            stall_cnt <= '0;
          end
        end
        STALL: begin
          if (!wfull) begin
            state <= BURST;
          end else if (timeout) begin
            state      <= IDLE;
            burst_busy <= 1'b0;
          end else begin
            stall_cnt <= stall_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky flags: a set event beats a simultaneous clear.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      words_written <= '0;
      err_timeout   <= 1'b0;
      err_overflow  <= 1'b0;
    end else begin
      if (winc) words_written <= words_written + 1'b1;
      if (timeout)      err_timeout <= 1'b1;
      else if (err_clr) err_timeout <= 1'b0;
      if (fifo_error_w) err_overflow <= 1'b1;
      else if (err_clr) err_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_wr_burst.sv
// tb/tb_fifo_wr_burst.sv - directed scoreboard bench for fifo_wr_burst
module tb_fifo_wr_burst;

  logic        wclk = 1'b0;
  logic        wrst_n;
  logic        burst_start;
  logic [7:0]  burst_len;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        winc;
  logic [7:0]  wdata;
  logic        wfull;
  logic        wfull_almost;
  logic        fifo_error_w;
  logic        err_clr;
  logic        burst_busy;
  logic        burst_done;
  logic [15:0] words_written;
  logic        err_timeout;
  logic        err_overflow;

  int          checks = 0;
  int          failures = 0;
  int          done_cnt = 0;
  logic [15:0] hist = '0;
  logic [7:0]  exp_q[$];

  fifo_wr_burst dut (
    .wclk(wclk), .wrst_n(wrst_n), .burst_start(burst_start), .burst_len(burst_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .winc(winc),
    .wdata(wdata), .wfull(wfull), .wfull_almost(wfull_almost),
    .fifo_error_w(fifo_error_w), .err_clr(err_clr), .burst_busy(burst_busy),
    .burst_done(burst_done), .words_written(words_written),
    .err_timeout(err_timeout), .err_overflow(err_overflow)
  );

  always #5 wclk = ~wclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(in_data + 8'(i));
  endtask

  // Sample at the falling edge, then advance to just after the next rising edge.
  task automatic tick();
    logic w;
    @(negedge wclk);
    w = winc;
    chk("winc_is_handshake", {31'd0, winc}, {31'd0, in_valid & in_ready});
    chk("no_winc_while_full", {31'd0, winc & wfull}, 32'd0);
    if (w) begin
      chk("winc_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) chk("wdata", {24'd0, wdata}, {24'd0, exp_q.pop_front()});
    end
    hist = {hist[14:0], w};
    if (burst_done) done_cnt++;
    @(posedge wclk);
    #1;
    if (w) in_data = in_data + 8'd1;
  endtask

  initial begin
    int n;
    wrst_n = 1'b0; burst_start = 1'b0; burst_len = '0; in_valid = 1'b1;
    in_data = 8'h10; wfull = 1'b0; wfull_almost = 1'b0; fifo_error_w = 1'b0; err_clr = 1'b0;
    repeat (2) @(posedge wclk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_busy", {31'd0, burst_busy}, 32'd0);
    chk("rst_done", {31'd0, burst_done}, 32'd0);
    chk("rst_words", {16'd0, words_written}, 32'd0);
    chk("rst_errs", {30'd0, err_timeout, err_overflow}, 32'd0);
    wrst_n = 1'b1;
    tick();

    // Four-word burst, producer always valid, FIFO never full.
    burst_start = 1'b1; burst_len = 8'd4; push_exp(4);
    tick();
    burst_start = 1'b0;
    chk("t1_ready_after_start", {31'd0, in_ready}, 32'd1);
    hist = '0;
    repeat (4) tick();
    chk("t1_pattern", {28'd0, hist[3:0]}, 32'h0000_000f);
    chk("t1_done_pulse", {31'd0, burst_done}, 32'd1);
    chk("t1_ready_in_done", {31'd0, in_ready}, 32'd0);
    tick();
    chk("t1_done_clear", {31'd0, burst_done}, 32'd0);
    chk("t1_words", {16'd0, words_written}, 32'd4);
    chk("t1_done_cnt", done_cnt, 32'd1);

    // Zero-length request is ignored.
    burst_start = 1'b1; burst_len = 8'd0;
    tick();
    burst_start = 1'b0;
    chk("t2_ready", {31'd0, in_ready}, 32'd0);
    chk("t2_busy", {31'd0, burst_busy}, 32'd0);
    tick();
    chk("t2_done_cnt", done_cnt, 32'd1);
    chk("t2_words", {16'd0, words_written}, 32'd4);

    // Eight words, FIFO full for five cycles after word three.
    burst_start = 1'b1; burst_len = 8'd8; push_exp(8);
    tick();
    burst_start = 1'b0;
    repeat (3) tick();
    wfull = 1'b1;
    repeat (5) tick();
    chk("t3_busy_in_stall", {31'd0, burst_busy}, 32'd1);
    wfull = 1'b0;
    n = 0;
    while (!burst_done && n < 40) begin tick(); n++; end
    chk("t3_done", {31'd0, burst_done}, 32'd1);
    chk("t3_resume_cycles", n, 32'd6);
    chk("t3_words", {16'd0, words_written}, 32'd12);
    chk("t3_no_timeout", {31'd0, err_timeout}, 32'd0);
    tick();
    chk("t3_done_cnt", done_cnt, 32'd2);
    chk("t3_queue_empty", exp_q.size(), 32'd0);

    // FIFO stuck full after word two: abort after sixteen stall cycles.
    burst_start = 1'b1; burst_len = 8'd8; push_exp(2);
    tick();
    burst_start = 1'b0;
    repeat (2) tick();
    wfull = 1'b1;
    repeat (16) tick();
    chk("t4_still_stalled", {31'd0, burst_busy}, 32'd1);
    chk("t4_no_early_timeout", {31'd0, err_timeout}, 32'd0);
    tick();
    chk("t4_idle", {31'd0, burst_busy}, 32'd0);
    chk("t4_timeout", {31'd0, err_timeout}, 32'd1);
    chk("t4_words", {16'd0, words_written}, 32'd14);
    chk("t4_done_cnt", done_cnt, 32'd2);
    chk("t4_queue_empty", exp_q.size(), 32'd0);
    wfull = 1'b0; err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t4_timeout_cleared", {31'd0, err_timeout}, 32'd0);

    // Overflow set wins over a simultaneous clear.
    fifo_error_w = 1'b1; err_clr = 1'b1;
    tick();
    fifo_error_w = 1'b0;
    chk("t5_overflow_set", {31'd0, err_overflow}, 32'd1);
    tick();
    err_clr = 1'b0;
    chk("t5_overflow_clr", {31'd0, err_overflow}, 32'd0);

    // Almost-full throttling.
    wfull_almost = 1'b1;
    burst_start = 1'b1; burst_len = 8'd4; push_exp(4);
    tick();
    burst_start = 1'b0;
    hist = '0;
`ifdef FIFO_WR_THROTTLE_ALMOST_EN
    repeat (7) tick();
    chk("t6_pattern", {25'd0, hist[6:0]}, 32'h0000_0055);
`else
    repeat (4) tick();
    chk("t6_pattern", {28'd0, hist[3:0]}, 32'h0000_000f);
`endif
    chk("t6_done", {31'd0, burst_done}, 32'd1);
    wfull_almost = 1'b0;
    tick();
    chk("t6_words", {16'd0, words_written}, 32'd18);

    // Reset mid-burst discards the burst.
    burst_start = 1'b1; burst_len = 8'd4; push_exp(2);
    tick();
    burst_start = 1'b0;
    repeat (2) tick();
    wrst_n = 1'b0;
    #1;
    chk("t7_busy", {31'd0, burst_busy}, 32'd0);
    chk("t7_ready", {31'd0, in_ready}, 32'd0);
    chk("t7_words", {16'd0, words_written}, 32'd0);
    tick();
    wrst_n = 1'b1;
    repeat (2) tick();
    chk("t7_no_done", done_cnt, 32'd3);
    chk("t7_queue_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_wr_burst.md
Name: fifo_wr_burst

Overview:
- Write-side burst controller sitting directly upstream of the async FIFO write-pointer/full logic, in the wclk domain.
- Accepts a burst request (length in words) and a valid/ready data stream from the producer.
- Drives winc/wdata into the FIFO write port, stalls on wfull, aborts on stall timeout and reports status/errors.

Parameters:
- DSIZE, 8, data word width.
- LENW, 8, width of burst length and remaining-word counter.
- STALL_MAX, 16, max consecutive STALL cycles before abort; must be >=1.
- CNTW, 16, width of total-words-written counter.

Ports:
- wclk  in  1  write clock.
- wrst_n  in  1  reset, asynchronous, active-low.
- burst_start  in  1  request pulse; sampled only in IDLE.
- burst_len  in  LENW  words in burst, sampled with burst_start; 0 = request ignored.
- in_valid  in  1  producer data valid.
- in_data  in  DSIZE  producer data.
- in_ready  out  1  controller can accept a word this cycle.
- winc  out  1  FIFO write increment; equals in_valid & in_ready.
- wdata  out  DSIZE  FIFO write data; combinational copy of in_data.
- wfull  in  1  registered FIFO full flag from write-pointer block.
- wfull_almost  in  1  registered almost-full flag.
- fifo_error_w  in  1  write-while-full indication from write-pointer block.
- err_clr  in  1  clears sticky error flags.
- burst_busy  out  1  high in BURST or STALL.
- burst_done  out  1  one-cycle pulse on successful burst completion.
- words_written  out  CNTW  total accepted words since reset; wraps.
- err_timeout  out  1  sticky; burst aborted by stall timeout.
- err_overflow  out  1  sticky; fifo_error_w seen.

Behaviour:
- Reset: state IDLE, rem=0, stall_cnt=0, in_ready=0, burst_busy=0, burst_done=0, words_written=0, err_timeout=0, err_overflow=0. Reset mid-burst discards the burst; no burst_done.
- States: IDLE, BURST, STALL, DONE; state, rem, stall_cnt and counters are registered.
- IDLE: in_ready=0. burst_start=1 & burst_len!=0 -> BURST next cycle, rem<=burst_len. burst_len==0 -> stay IDLE, no flags.
- BURST: in_ready = ~wfull (plus optional throttle gating). An accept (winc=1) decrements rem and increments words_written.
  - Accept with rem==1 -> DONE.
  - Else wfull=1 -> STALL, stall_cnt<=0.
  - Otherwise stay in BURST. in_valid=0 is not a stall.
- STALL: in_ready=0, stall_cnt increments each cycle.
  - wfull=0 -> BURST next cycle.
  - wfull=1 & stall_cnt==STALL_MAX-1 -> IDLE, err_timeout<=1, no burst_done.
- DONE: burst_done=1 for exactly one cycle, in_ready=0, then IDLE. A burst_start during DONE is ignored.
- burst_start outside IDLE: ignored.
- wfull is registered one cycle after the filling write, so a write issued in the filling cycle is legal; the cycle after, wfull=1 blocks in_ready. No winc while wfull=1 under any condition.
- err_overflow<=1 whenever fifo_error_w=1.
- Sticky errors: err_clr clears both; a set event in the same cycle as err_clr wins.
- words_written wraps modulo 2^CNTW; rem never underflows.
- Latency: zero cycles from accept to winc (combinational); one cycle from burst_start to first possible accept.

Optional Feature:
- Macro FIFO_WR_THROTTLE_ALMOST_EN.
- Defined: while wfull_almost=1 in BURST, in_ready is forced 0 in the cycle after any accept, giving at most one write per two cycles until wfull_almost drops.
- Undefined: wfull_almost is ignored; back-to-back writes allowed until wfull.

Test Plan:
- Reset, then burst_start with burst_len=4, in_valid held 1, wfull=0 -> winc high 4 consecutive cycles starting 1 cycle after start; burst_done pulses once; words_written=4.
- burst_len=0 with burst_start -> stays IDLE, in_ready=0, burst_busy=0, no burst_done.
- burst_len=8, wfull asserted after word 3 for 5 cycles (STALL_MAX=16) -> no winc while wfull=1; resumes and completes 8 words; burst_done=1; err_timeout=0.
- burst_len=8, wfull held 1 after word 2 -> after 16 STALL cycles returns to IDLE; err_timeout=1; words_written=2; no burst_done; err_clr then clears err_timeout.
- fifo_error_w pulsed with err_clr asserted in the same cycle -> err_overflow=1. Next cycle err_clr alone -> err_overflow=0.
- With FIFO_WR_THROTTLE_ALMOST_EN and wfull_almost=1, burst_len=4 -> winc on alternate cycles; burst completes in 7 cycles of BURST. Without the macro -> 4 consecutive cycles.
